// File: rtl/bus_arbiter_pkg.sv
// Shared bus-master constants: channel count, owner encodings, grant polarity.
// Owner-to-grant decode helper used by the arbiter and its picker.
package bus_arbiter_pkg;

    localparam int BUS_MASTER_CH = 4;

    typedef logic [1:0] owner_t;

    localparam owner_t BUS_OWNER_MASTER_0 = 2'h0;
    localparam owner_t BUS_OWNER_MASTER_1 = 2'h1;
    localparam owner_t BUS_OWNER_MASTER_2 = 2'h2;
    localparam owner_t BUS_OWNER_MASTER_3 = 2'h3;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Active-high one-hot of the owning master.
    function automatic logic [BUS_MASTER_CH-1:0] owner_decode(input owner_t o);
        logic [BUS_MASTER_CH-1:0] dec;
        dec    = '0;
        dec[o] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Round-robin picker: first requester after the current owner, in circular order.
// Latency: combinational; backpressure: none.
module bus_rr_pick
    import bus_arbiter_pkg::*;
(
    input  owner_t                   owner,
    input  logic [BUS_MASTER_CH-1:0] req,
    output logic                     found,
    output owner_t                   next_owner
);

    owner_t c1;
    owner_t c2;
    owner_t c3;

    // 2-bit add wraps naturally, so owner 3 searches 0, 1, 2.
    assign c1 = owner + 2'd1;
    assign c2 = owner + 2'd2;
    assign c3 = owner + 2'd3;

    always_comb begin
        found      = 1'b1;
        next_owner = owner;
        if (req[c1]) begin
            next_owner = c1;
        end else if (req[c2]) begin
            next_owner = c2;
        end else if (req[c3]) begin
            next_owner = c3;
        end else begin
            found = 1'b0;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// 4-master round-robin bus arbiter, active-low req/grant, parking, optional max-hold preemption.
// Latency: 1 cycle req->grant (registered owner); backpressure: none, req_ is level-sampled.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 0,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       owner_chg
);

    localparam int HOLD_LIM = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    logic [BUS_MASTER_CH-1:0] req;
    logic [BUS_MASTER_CH-1:0] owner_oh;
    logic [HOLD_W-1:0]        hold_cnt;
    logic [HOLD_W-1:0]        hold_nxt;
    owner_t                   owner_nxt;
    owner_t                   pick_owner;
    logic                     pick_found;
    logic                     own_req;
    logic                     others_req;
    logic                     preempt;
    logic                     switch_own;
    logic                     chg_nxt;

    assign req        = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign owner_oh   = owner_decode(owner);
    assign own_req    = req[owner];
    assign others_req = |(req & ~owner_oh);

    bus_rr_pick u_pick (
        .owner      (owner),
        .req        (req),
        .found      (pick_found),
        .next_owner (pick_owner)
    );

    // hold_cnt counts from 0 in the first owned cycle, so LIM = MAX_HOLD-1 yields MAX_HOLD cycles.
    assign preempt    = (MAX_HOLD != 0) && own_req && others_req &&
                        (hold_cnt >= HOLD_W'(HOLD_LIM));
    assign switch_own = (!own_req && pick_found) || preempt;

    always_comb begin
        owner_nxt = owner;
        hold_nxt  = hold_cnt;
        chg_nxt   = 1'b0;
        if (switch_own) begin
            owner_nxt = pick_owner;
            hold_nxt  = '0;
            chg_nxt   = 1'b1;
        end else if (own_req) begin
            hold_nxt = (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= BUS_OWNER_MASTER_0;
            hold_cnt  <= '0;
            owner_chg <= 1'b0;
        end else begin
            owner     <= owner_nxt;
            hold_cnt  <= hold_nxt;
            owner_chg <= chg_nxt;
        end
    end

    assign m0_grnt_ = owner_oh[0] ? ENABLE_ : DISABLE_;
    assign m1_grnt_ = owner_oh[1] ? ENABLE_ : DISABLE_;
    assign m2_grnt_ = owner_oh[2] ? ENABLE_ : DISABLE_;
    assign m3_grnt_ = owner_oh[3] ? ENABLE_ : DISABLE_;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: MAX_HOLD=4 and MAX_HOLD=0 instances share stimulus, scoreboarded against a model.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_;
    logic [3:0] g4, g0;
    logic [1:0] own4, own0;
    logic       chg4, chg0;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) u_dut4 (
        .clk(clk), .reset(reset),
        .m0_req_(req_[0]), .m1_req_(req_[1]), .m2_req_(req_[2]), .m3_req_(req_[3]),
        .m0_grnt_(g4[0]), .m1_grnt_(g4[1]), .m2_grnt_(g4[2]), .m3_grnt_(g4[3]),
        .owner(own4), .owner_chg(chg4)
    );

    bus_arbiter #(.MAX_HOLD(0), .HOLD_W(8)) u_dut0 (
        .clk(clk), .reset(reset),
        .m0_req_(req_[0]), .m1_req_(req_[1]), .m2_req_(req_[2]), .m3_req_(req_[3]),
        .m0_grnt_(g0[0]), .m1_grnt_(g0[1]), .m2_grnt_(g0[2]), .m3_grnt_(g0[3]),
        .owner(own0), .owner_chg(chg0)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state: index 0 models MAX_HOLD=4, index 1 models MAX_HOLD=0.
    int   m_owner[2];
    int   m_hold[2];
    logic m_chg[2];
    logic [6:0] sb4[$];
    logic [6:0] sb0[$];

    function automatic logic [6:0] pack(input int o, input logic c);
        logic [3:0] g;
        g = 4'hF;
        g[o] = 1'b0;
        return {c, g, 2'(o)};
    endfunction

    task automatic model_step(input int i, input int mh, input logic [3:0] r, input logic rst);
        int o, h, win;
        bit found, take;
        o = m_owner[i];
        h = m_hold[i];
        if (rst) begin
            m_owner[i] = 0;
            m_hold[i]  = 0;
            m_chg[i]   = 1'b0;
        end else begin
            found = 0;
            win   = o;
            for (int k = 1; k < 4; k++) begin
                if (!found && r[(o + k) % 4]) begin
                    found = 1;
                    win   = (o + k) % 4;
                end
            end
            if (!r[o]) take = found;
            else       take = (mh != 0) && found && (h >= mh - 1);
            if (take) begin
                m_owner[i] = win;
                m_hold[i]  = 0;
                m_chg[i]   = 1'b1;
            end else begin
                m_chg[i] = 1'b0;
                if (r[o] && h < 255) m_hold[i] = h + 1;
            end
        end
    endtask

    // Drive one cycle of stimulus (r is active-high), then compare both DUTs after the edge.
    task automatic step(input logic [3:0] r, input logic rst);
        @(negedge clk);
        req_  = ~r;
        reset = rst;
        model_step(0, 4, r, rst);
        model_step(1, 0, r, rst);
        sb4.push_back(pack(m_owner[0], m_chg[0]));
        sb0.push_back(pack(m_owner[1], m_chg[1]));
        @(posedge clk);
        #1;
        check("sb_dut4", {25'd0, chg4, g4, own4}, {25'd0, sb4.pop_front()});
        check("sb_dut0", {25'd0, chg0, g0, own0}, {25'd0, sb0.pop_front()});
    endtask

    initial begin
        int cnt4, cnt0;
        logic [3:0] r;
        logic rr;
        reset = 1'b1;
        req_  = 4'hF;
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = 0;
            m_hold[i]  = 0;
            m_chg[i]   = 1'b0;
        end

        // Reset then idle parking on master 0
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("rst_owner", {30'd0, own4}, 32'd0);
        check("rst_grnt", {28'd0, g4}, 32'hE);
        check("rst_chg", {31'd0, chg4}, 32'd0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        check("park0_grnt", {28'd0, g0}, 32'hE);

        // Owner 0 idle, m2 requests
        step(4'b0100, 1'b0);
        check("m2_owner", {30'd0, own4}, 32'd2);
        check("m2_chg", {31'd0, chg4}, 32'd1);
        step(4'b0100, 1'b0);
        check("m2_chg_pulse", {31'd0, chg4}, 32'd0);

        // Move to owner 3, then release with m0,m1 requesting: wraps to 0
        step(4'b1000, 1'b0);
        check("m3_owner", {30'd0, own4}, 32'd3);
        step(4'b0011, 1'b0);
        check("wrap_owner", {30'd0, own4}, 32'd0);
        check("wrap_grnt", {28'd0, g4}, 32'hE);

        // m1 owns, m2 contends from ownership cycle 0
        step(4'b0010, 1'b0);
        cnt4 = (g4[1] == 1'b0) ? 1 : 0;
        cnt0 = (g0[1] == 1'b0) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            step(4'b0110, 1'b0);
            if (g4[1] == 1'b0) cnt4++;
            if (g0[1] == 1'b0) cnt0++;
        end
        check("hold4_cycles", cnt4, 32'd4);
        check("hold4_owner", {30'd0, own4}, 32'd2);
        check("hold0_cycles", cnt0, 32'd7);

        // dut0 owner 1 releases with nobody requesting: parks, then re-request has no pulse
        step(4'b0000, 1'b0);
        check("park1_owner", {30'd0, own0}, 32'd1);
        check("park1_chg", {31'd0, chg0}, 32'd0);
        step(4'b0010, 1'b0);
        check("rereq_chg", {31'd0, chg0}, 32'd0);
        check("rereq_grnt", {28'd0, g0}, 32'hD);

        // Owner 2 with hold_cnt 3, reset mid-ownership
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        check("pre_rst_owner", {30'd0, own4}, 32'd2);
        step(4'b0100, 1'b1);
        check("mid_rst_owner", {30'd0, own4}, 32'd0);
        check("mid_rst_chg", {31'd0, chg4}, 32'd0);
        check("mid_rst_grnt", {28'd0, g4}, 32'hE);
        step(4'b0100, 1'b0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            r  = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 49) == 0);
            step(r, rr);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
